// File: rtl/mem_sequencer.sv
// Command-driven burst sequencer: deserializer -> block RAM writes, block RAM -> serializer reads.
// Optional MEMSEQ_BOUNDS_EN adds an err output and rejects out-of-range commands at acceptance.
module mem_sequencer #(
  parameter int NUM_BLOCKS = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  localparam int BSEL_W    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
`ifdef MEMSEQ_BOUNDS_EN
  output logic                             err,
`endif
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [BSEL_W-1:0]                cmd_block,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [LEN_WIDTH-1:0]             cmd_len,
  output logic [NUM_BLOCKS-1:0]            blockena,
  output logic [NUM_BLOCKS-1:0]            blockwea,
  output logic [ADDR_WIDTH-1:0]            blockaddr,
  output logic [DATA_WIDTH-1:0]            blockdin,
  input  logic [NUM_BLOCKS*DATA_WIDTH-1:0] blockdout,
  output logic                             deseriena,
  input  logic                             deservalid,
  input  logic [DATA_WIDTH-1:0]            deserdata,
  output logic                             seriena,
  output logic [DATA_WIDTH-1:0]            seridata,
  input  logic                             seriready,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_ISSUE, S_RD_WAIT, S_RD_PUSH, S_DONE
  } state_t;

  state_t                  r_state;
  logic [BSEL_W-1:0]       r_blk;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_rem;
  logic [DATA_WIDTH-1:0]   r_seridata;
  logic [NUM_BLOCKS-1:0]   w_sel;
  logic [DATA_WIDTH-1:0]   w_rd;
  logic                    w_bad;

`ifdef MEMSEQ_BOUNDS_EN
  localparam int SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
  logic [SUM_W-1:0] w_end;
  logic             r_err;

  always_comb begin
    w_end = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    w_bad = (int'(cmd_block) >= NUM_BLOCKS) || (|w_end[SUM_W-1:ADDR_WIDTH]);
  end

  assign err = (r_state == S_DONE) && r_err;
`else
  assign w_bad = 1'b0;
`endif

  // An out-of-range block index matches no bit, so it yields no enables and reads 0.
  always_comb begin
    w_sel = '0;
    w_rd  = '0;
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      if (r_blk == BSEL_W'(k)) begin
        w_sel[k] = 1'b1;
        w_rd     = blockdout[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    blockena  = '0;
    blockwea  = '0;
    blockaddr = '0;
    blockdin  = '0;
    case (r_state)
      S_WRITE: begin
        if (deservalid && (|w_sel)) begin
          blockena  = w_sel;
          blockwea  = w_sel;
          blockaddr = r_addr;
          blockdin  = deserdata;
        end
      end
      S_RD_ISSUE: begin
        if (|w_sel) begin
          blockena  = w_sel;
          blockaddr = r_addr;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign deseriena = (r_state == S_WRITE);
  assign seriena   = (r_state == S_RD_PUSH);
  assign seridata  = r_seridata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_blk      <= '0;
      r_addr     <= '0;
      r_rem      <= '0;
      r_seridata <= '0;
`ifdef MEMSEQ_BOUNDS_EN
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_blk  <= cmd_block;
            r_addr <= cmd_addr;
            r_rem  <= cmd_len;
`ifdef MEMSEQ_BOUNDS_EN
            r_err  <= w_bad;
`endif
            if (w_bad)          r_state <= S_DONE;
            else if (cmd_write) r_state <= S_WRITE;
            else                r_state <= S_RD_ISSUE;
          end
        end
        S_WRITE: begin
          if (deservalid) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            if (r_rem == '0) r_state <= S_DONE;
            else             r_rem   <= r_rem - LEN_WIDTH'(1);
          end
        end
        S_RD_ISSUE: r_state <= S_RD_WAIT;
        // RAM output is valid one cycle after the issue; capture it here and hold until accepted.
        S_RD_WAIT: begin
          r_seridata <= w_rd;
          r_state    <= S_RD_PUSH;
        end
        S_RD_PUSH: begin
          if (seriready) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            if (r_rem == '0) begin
              r_state <= S_DONE;
            end else begin
              r_rem   <= r_rem - LEN_WIDTH'(1);
              r_state <= S_RD_ISSUE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a two-block behavioural RAM model.
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_write;
  logic        cmd_ready;
  logic [0:0]  cmd_block;
  logic [9:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [1:0]  blockena, blockwea;
  logic [9:0]  blockaddr;
  logic [7:0]  blockdin;
  logic [15:0] blockdout;
  logic        deseriena, deservalid;
  logic [7:0]  deserdata;
  logic        seriena, seriready;
  logic [7:0]  seridata;
  logic        busy, done;
`ifdef MEMSEQ_BOUNDS_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mem_sequencer #(.NUM_BLOCKS(2), .ADDR_WIDTH(10), .DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
`ifdef MEMSEQ_BOUNDS_EN
    .err(err),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_block(cmd_block), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .blockena(blockena), .blockwea(blockwea), .blockaddr(blockaddr),
    .blockdin(blockdin), .blockdout(blockdout),
    .deseriena(deseriena), .deservalid(deservalid), .deserdata(deserdata),
    .seriena(seriena), .seridata(seridata), .seriready(seriready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];
  logic [7:0] dout0, dout1;
  assign blockdout = {dout1, dout0};

  always @(posedge clk) begin
    if (blockena[0]) begin
      if (blockwea[0]) mem0[blockaddr] <= blockdin;
      dout0 <= mem0[blockaddr];
    end
    if (blockena[1]) begin
      if (blockwea[1]) mem1[blockaddr] <= blockdin;
      dout1 <= mem1[blockaddr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one edge; returns 1 time unit into the first post-accept cycle.
  task automatic send_cmd(input logic w, input logic blk, input logic [9:0] addr,
                          input logic [7:0] len);
    cmd_valid = 1'b1; cmd_write = w; cmd_block = blk; cmd_addr = addr; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_block = '0;
    cmd_addr = '0; cmd_len = '0; deservalid = 1'b0; deserdata = '0; seriready = 1'b0;
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_done",      32'(done), 32'd0);
    chk("rst_blockena",  32'(blockena), 32'd0);
    chk("rst_blockaddr", 32'(blockaddr), 32'd0);
    chk("rst_deseriena", 32'(deseriena), 32'd0);
    chk("rst_seriena",   32'(seriena), 32'd0);
    chk("rst_seridata",  32'(seridata), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Reset mid-write after two of four words
    send_cmd(1'b1, 1'b0, 10'h020, 8'd3);
    #1;
    chk("wr_gap_deseriena", 32'(deseriena), 32'd1);
    chk("wr_gap_blockena",  32'(blockena), 32'd0);
    chk("wr_gap_blockaddr", 32'(blockaddr), 32'd0);
    tick();
    deservalid = 1'b1; deserdata = 8'h11; #1;
    chk("rstw_ena0",  32'(blockena), 32'd1);
    chk("rstw_wea0",  32'(blockwea), 32'd1);
    chk("rstw_addr0", 32'(blockaddr), 32'h020);
    chk("rstw_din0",  32'(blockdin), 32'h11);
    tick();
    deserdata = 8'h22; #1;
    chk("rstw_addr1", 32'(blockaddr), 32'h021);
    tick();
    deserdata = 8'h33; #1;
    reset = 1'b1; #1;
    chk("rstw_blockena",  32'(blockena), 32'd0);
    chk("rstw_deseriena", 32'(deseriena), 32'd0);
    chk("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstw_done",      32'(done), 32'd0);
    deservalid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("rstw_done_after", 32'(done), 32'd0);
    chk("rstw_mem20", 32'(mem0[10'h020]), 32'h11);
    chk("rstw_mem21", 32'(mem0[10'h021]), 32'h22);

    // Four-word write to block 1
    send_cmd(1'b1, 1'b1, 10'h010, 8'd3);
    for (int i = 0; i < 4; i++) begin
      deservalid = 1'b1; deserdata = 8'hA0 + 8'(i); #1;
      chk("wr_ena",  32'(blockena), 32'd2);
      chk("wr_wea",  32'(blockwea), 32'd2);
      chk("wr_addr", 32'(blockaddr), 32'h010 + 32'(i));
      chk("wr_din",  32'(blockdin), 32'hA0 + 32'(i));
      tick();
    end
    deservalid = 1'b0; #1;
    chk("wr_done",      32'(done), 32'd1);
    chk("wr_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("wr_ready_after", 32'(cmd_ready), 32'd1);
    chk("wr_done_after",  32'(done), 32'd0);

    // Four-word readback, serializer always ready
    seriready = 1'b1;
    send_cmd(1'b0, 1'b1, 10'h010, 8'd3);
    for (int c = 1; c <= 13; c++) begin
      #1;
      if (c == 1) begin
        chk("rd_issue_ena",  32'(blockena), 32'd2);
        chk("rd_issue_wea",  32'(blockwea), 32'd0);
        chk("rd_issue_addr", 32'(blockaddr), 32'h010);
      end
      chk("rd_seriena", 32'(seriena), ((c % 3 == 0) && c <= 12) ? 32'd1 : 32'd0);
      if ((c % 3 == 0) && c <= 12)
        chk("rd_seridata", 32'(seridata), 32'hA0 + 32'(c / 3 - 1));
      chk("rd_done", 32'(done), (c == 13) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    chk("rd_ready_after", 32'(cmd_ready), 32'd1);

    // Two-word read with a five-cycle stall on word 0
    seriready = 1'b0;
    send_cmd(1'b0, 1'b1, 10'h010, 8'd1);
    for (int c = 1; c <= 11; c++) begin
      if (c == 4) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_block = 1'b0; cmd_addr = '0; cmd_len = '0;
      end
      if (c == 5) cmd_valid = 1'b0;
      #1;
      if (c >= 3 && c <= 7) begin
        chk("stall_seriena",  32'(seriena), 32'd1);
        chk("stall_seridata", 32'(seridata), 32'hA0);
        chk("stall_blockena", 32'(blockena), 32'd0);
      end
      if (c == 4) chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      if (c == 7) seriready = 1'b1;
      if (c == 8) begin
        chk("stall_issue_ena",  32'(blockena), 32'd2);
        chk("stall_issue_addr", 32'(blockaddr), 32'h011);
      end
      if (c == 10) begin
        chk("stall_w1_seriena",  32'(seriena), 32'd1);
        chk("stall_w1_seridata", 32'(seridata), 32'hA1);
      end
      chk("stall_done", 32'(done), (c == 11) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    chk("stall_not_queued", 32'(busy), 32'd0);
    tick();

    // Burst starting at the top address
    send_cmd(1'b1, 1'b0, 10'h3FF, 8'd1);
`ifdef MEMSEQ_BOUNDS_EN
    #1;
    chk("bnd_err",       32'(err), 32'd1);
    chk("bnd_done",      32'(done), 32'd1);
    chk("bnd_blockena",  32'(blockena), 32'd0);
    chk("bnd_deseriena", 32'(deseriena), 32'd0);
    tick();
    chk("bnd_err_after", 32'(err), 32'd0);
`else
    deservalid = 1'b1; deserdata = 8'h5A; #1;
    chk("wrap_addr0", 32'(blockaddr), 32'h3FF);
    tick();
    deserdata = 8'h5B; #1;
    chk("wrap_addr1", 32'(blockaddr), 32'h000);
    tick();
    deservalid = 1'b0; #1;
    chk("wrap_done", 32'(done), 32'd1);
    tick();
    chk("wrap_mem3ff", 32'(mem0[10'h3FF]), 32'h5A);
    chk("wrap_mem000", 32'(mem0[10'h000]), 32'h5B);
`endif
    tick();

    // Single-word read: seriena at T+3, done at T+4
    seriready = 1'b1;
    send_cmd(1'b0, 1'b0, 10'h020, 8'd0);
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("rd1_seriena", 32'(seriena), (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) chk("rd1_seridata", 32'(seridata), 32'h11);
      chk("rd1_done", 32'(done), (c == 4) ? 32'd1 : 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
